sdram_arbiter: RTL and testbench



---
 rtl/sdram_pkg.sv | 15 +
 rtl/sdram_arbiter_rr_pick.sv | 52 +++++
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared constants for the SDRAM host-side blocks.
//   SDRAM_ADDR_W / SDRAM_DATA_W / SDRAM_BSEL_W : host port field widths.
//   arb_state_e : sdram_arbiter FSM state encoding.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 32;
  localparam int SDRAM_DATA_W = 16;
  localparam int SDRAM_BSEL_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode.
//   eligible_i : one bit per port, set when the port may be granted.
//   last_i     : index of the most recently granted port.
//   winner_o   : index of the selected port (valid only with valid_o).
//   valid_o    : at least one eligible port exists.
// Default: first eligible port searching last_i+1, last_i+2, ... mod NUM_PORTS.
// With SDRAM_ARB_FIXED_PRIO_EN defined: lowest eligible index, last_i unused.
module rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible_i,
  input  logic [PTR_W-1:0]     last_i,
  output logic [PTR_W-1:0]     winner_o,
  output logic                 valid_o
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    // Descending walk: the last hit is the lowest eligible index.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        winner_o = PTR_W'(i);
        valid_o  = 1'b1;
      end
    end
  end
`else
  int idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    // Walk offsets from farthest to nearest so the last hit is the first
    // eligible port after last_i in round-robin order.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_PORTS;
      if (eligible_i[idx]) begin
        winner_o = PTR_W'(idx);
        valid_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller host port between NUM_PORTS
// requesters. A request is a non-zero p_bytesel held stable until that
// port's one-cycle p_compl pulse; the m_* side follows the same protocol.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset.
//   p_addr/p_wdata      : per-port address (32b) / write data (16b), packed.
//   p_wr_en/p_bytesel   : per-port write flag / byte enables (non-zero = request).
//   p_rdata/p_compl     : shared read data, one-hot completion pulse.
//   m_addr/m_wdata/m_wr_en/m_bytesel : registered controller host request.
//   m_rdata/m_compl     : controller response.
//   grant               : current or last granted port (debug).
// Build option: SDRAM_ARB_FIXED_PRIO_EN selects strict lowest-index priority
// instead of round-robin.
// The FSM state is held in state_q (arb_state_e) for debug/assertion binding.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS*SDRAM_ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*SDRAM_DATA_W-1:0] p_wdata,
  input  logic [NUM_PORTS-1:0]              p_wr_en,
  input  logic [NUM_PORTS*SDRAM_BSEL_W-1:0] p_bytesel,
  output logic [SDRAM_DATA_W-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]              p_compl,
  output logic [SDRAM_ADDR_W-1:0]           m_addr,
  output logic [SDRAM_DATA_W-1:0]           m_wdata,
  output logic                              m_wr_en,
  output logic [SDRAM_BSEL_W-1:0]           m_bytesel,
  input  logic [SDRAM_DATA_W-1:0]           m_rdata,
  input  logic                              m_compl,
  output logic [PTR_W-1:0]                  grant
);

  arb_state_e               state_q, state_d;
  logic [PTR_W-1:0]         grant_q, grant_d;
  logic [SDRAM_ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [SDRAM_DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic                     m_wr_en_q, m_wr_en_d;
  logic [SDRAM_BSEL_W-1:0]  m_bsel_q, m_bsel_d;
  logic [NUM_PORTS-1:0]     p_compl_q, p_compl_d;
  logic [SDRAM_DATA_W-1:0]  p_rdata_q, p_rdata_d;

  logic [NUM_PORTS-1:0]     req;
  logic [NUM_PORTS-1:0]     pick_vec;
  logic [PTR_W-1:0]         pick_idx;
  logic                     pick_valid;
  logic                     win_ok;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = |p_bytesel[i*SDRAM_BSEL_W +: SDRAM_BSEL_W];
    end
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // A just-completed higher-priority port still blocks lower ones for its
  // one excluded cycle, so a continuously requesting port 0 keeps the bus.
  assign pick_vec = req;
`else
  // A port completed last cycle still shows its old request; skip it.
  assign pick_vec = req & ~p_compl_q;
`endif

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .eligible_i (pick_vec),
    .last_i     (grant_q),
    .winner_o   (pick_idx),
    .valid_o    (pick_valid)
  );

  assign win_ok = pick_valid & ~p_compl_q[pick_idx];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wr_en_d = m_wr_en_q;
    m_bsel_d  = m_bsel_q;
    p_compl_d = '0;
    p_rdata_d = p_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        // m_compl here is a leftover from before reset and is ignored.
        if (win_ok) begin
          m_addr_d  = p_addr[pick_idx*SDRAM_ADDR_W +: SDRAM_ADDR_W];
          m_wdata_d = p_wdata[pick_idx*SDRAM_DATA_W +: SDRAM_DATA_W];
          m_wr_en_d = p_wr_en[pick_idx];
          m_bsel_d  = p_bytesel[pick_idx*SDRAM_BSEL_W +: SDRAM_BSEL_W];
          grant_d   = pick_idx;
          state_d   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (m_compl) begin
          p_rdata_d          = m_rdata;
          p_compl_d[grant_q] = 1'b1;
          m_bsel_d           = '0;
          m_wr_en_d          = 1'b0;
          m_addr_d           = '0;
          state_d            = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= PTR_W'(NUM_PORTS - 1);
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wr_en_q <= 1'b0;
      m_bsel_q  <= '0;
      p_compl_q <= '0;
      p_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wr_en_q <= m_wr_en_d;
      m_bsel_q  <= m_bsel_d;
      p_compl_q <= p_compl_d;
      p_rdata_q <= p_rdata_d;
    end
  end

  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_bytesel = m_bsel_q;
  assign p_compl   = p_compl_q;
  assign p_rdata   = p_rdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NP = 2;
  localparam int PW = $clog2(NP);

  logic               clk;
  logic               rst_n;
  logic [NP*32-1:0]   p_addr;
  logic [NP*16-1:0]   p_wdata;
  logic [NP-1:0]      p_wr_en;
  logic [NP*2-1:0]    p_bytesel;
  logic [15:0]        p_rdata;
  logic [NP-1:0]      p_compl;
  logic [31:0]        m_addr;
  logic [15:0]        m_wdata;
  logic               m_wr_en;
  logic [1:0]         m_bytesel;
  logic [15:0]        m_rdata;
  logic               m_compl;
  logic [PW-1:0]      grant;

  int checks;
  int errors;
  int cyc = 0;

  // Controller model knobs (written only by the main initial block).
  int          ctrl_lat   = 1;
  bit          ctrl_rand  = 1'b0;
  logic [15:0] ctrl_rdata = 16'h0000;
  int          stray_tok  = 0;

  // Scoreboard: expected order of completions (port indices).
  logic [PW-1:0] exp_q[$];

  sdram_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_wr_en   (p_wr_en),
    .p_bytesel (p_bytesel),
    .p_rdata   (p_rdata),
    .p_compl   (p_compl),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wr_en   (m_wr_en),
    .m_bytesel (m_bytesel),
    .m_rdata   (m_rdata),
    .m_compl   (m_compl),
    .grant     (grant)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- controller model ----------------
  // Raises m_compl in the lat-th cycle that m_bytesel is non-zero.
  // Updates 2ns after the rising edge so values are stable at the negedge.
  initial begin : ctrl_model
    int cnt;
    int lat;
    int seen;
    cnt = 0; lat = 1; seen = 0;
    m_compl = 1'b0;
    m_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      m_compl = 1'b0;
      if (stray_tok != seen) begin
        seen    = stray_tok;
        m_compl = 1'b1;
        m_rdata = 16'h0BAD;
      end else if (m_bytesel != 2'b00) begin
        if (cnt == 0) lat = ctrl_rand ? int'($urandom_range(1, 5)) : ctrl_lat;
        cnt++;
        if (cnt >= lat) begin
          m_compl = 1'b1;
          m_rdata = ctrl_rand ? 16'($urandom) : ctrl_rdata;
          cnt     = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] d,
                         input logic w, input logic [1:0] b);
    p_addr[i*32 +: 32]   = a;
    p_wdata[i*16 +: 16]  = d;
    p_wr_en[i]           = w;
    p_bytesel[i*2 +: 2]  = b;
  endtask

  task automatic clr_req(input int i);
    p_bytesel[i*2 +: 2] = 2'b00;
    p_wr_en[i]          = 1'b0;
  endtask

  task automatic new_req(input int i);
    set_req(i, $urandom, 16'($urandom), 1'($urandom), 2'($urandom_range(1, 3)));
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    p_bytesel = '0;
    p_wr_en   = '0;
    p_addr    = '0;
    p_wdata   = '0;
    ctrl_rand = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag, output int at);
    int n = 0;
    at = -1;
    while (m_bytesel == 2'b00 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (m_bytesel == 2'b00) begin
      errors++;
      $display("FAIL %s_start: m_bytesel=%b after 40 cycles, required non-zero", tag, m_bytesel);
    end else at = cyc;
  endtask

  task automatic wait_compl(input string tag, output int at);
    int n = 0;
    at = -1;
    while (m_compl !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (m_compl !== 1'b1) begin
      errors++;
      $display("FAIL %s_compl: m_compl=%b after 60 cycles, required 1", tag, m_compl);
    end else at = cyc;
  endtask

  // ---------------- reference model ----------------
  // Next port to grant, or -1. Round-robin: first requesting port after
  // 'last', skipping the port whose completion is being signalled.
  function automatic int ref_pick(input logic [NP*2-1:0] bsel, input logic [NP-1:0] done,
                                  input int last);
    int j;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NP; i++) begin
      if (bsel[i*2 +: 2] != 2'b00) return done[i] ? -1 : i;
    end
    return -1;
`else
    for (int k = 1; k <= NP; k++) begin
      j = (last + k) % NP;
      if (bsel[j*2 +: 2] != 2'b00 && !done[j]) return j;
    end
    return -1;
`endif
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [PW-1:0] g_rst;
    g_rst = PW'(NP - 1);
    rst_n = 1'b0;
    p_bytesel = '0; p_wr_en = '0; p_addr = '0; p_wdata = '0;
    @(negedge clk);
    checks++; if (p_compl !== '0) begin errors++; $display("FAIL reset_p_compl: got %b want 0", p_compl); end
    checks++; if (p_rdata !== 16'h0) begin errors++; $display("FAIL reset_p_rdata: got %h want 0", p_rdata); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
    checks++; if (m_wdata !== 16'h0) begin errors++; $display("FAIL reset_m_wdata: got %h want 0", m_wdata); end
    checks++; if (m_wr_en !== 1'b0) begin errors++; $display("FAIL reset_m_wr_en: got %b want 0", m_wr_en); end
    checks++; if (m_bytesel !== 2'b00) begin errors++; $display("FAIL reset_m_bytesel: got %b want 00", m_bytesel); end
    checks++; if (grant !== g_rst) begin errors++; $display("FAIL reset_grant: got %0d want %0d", grant, g_rst); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_bytesel !== 2'b00) begin errors++; $display("FAIL reset_idle: m_bytesel got %b want 00", m_bytesel); end
  endtask

  task automatic test_single_read();
    int s, t;
    ctrl_rand = 1'b0; ctrl_lat = 6; ctrl_rdata = 16'hBEEF;
    set_req(1, 32'h0000_1234, 16'h0000, 1'b0, 2'b11);
    @(negedge clk);
    checks++; if (m_bytesel !== 2'b11 || m_addr !== 32'h1234) begin errors++;
      $display("FAIL read_issue: m_bytesel=%b m_addr=%h want 11 00001234", m_bytesel, m_addr); end
    checks++; if (m_wr_en !== 1'b0 || grant !== PW'(1)) begin errors++;
      $display("FAIL read_grant: m_wr_en=%b grant=%0d want 0 1", m_wr_en, grant); end
    s = cyc;
    wait_compl("read", t);
    checks++; if (t - s != 5 || m_bytesel !== 2'b11) begin errors++;
      $display("FAIL read_hold: compl after %0d cycles bytesel=%b want 5 11", t - s, m_bytesel); end
    @(negedge clk);
    checks++; if (p_compl !== 2'b10 || p_rdata !== 16'hBEEF) begin errors++;
      $display("FAIL read_compl: p_compl=%b p_rdata=%h want 10 beef", p_compl, p_rdata); end
    checks++; if (m_bytesel !== 2'b00 || m_addr !== 32'h0) begin errors++;
      $display("FAIL read_release: m_bytesel=%b m_addr=%h want 00 0", m_bytesel, m_addr); end
    clr_req(1);
    @(negedge clk);
    checks++; if (p_compl !== 2'b00) begin errors++; $display("FAIL read_pulse: p_compl=%b want 00", p_compl); end
  endtask

  task automatic test_write();
    int t;
    ctrl_rand = 1'b0; ctrl_lat = 3;
    checks++; if (m_wr_en !== 1'b0) begin errors++; $display("FAIL wr_idle: m_wr_en=%b want 0", m_wr_en); end
    set_req(0, 32'h0000_0040, 16'hA5A5, 1'b1, 2'b01);
    @(negedge clk);
    while (m_compl !== 1'b1 && m_bytesel != 2'b00) begin
      checks++; if (m_wr_en !== 1'b1 || m_wdata !== 16'hA5A5 || m_bytesel !== 2'b01 || grant !== PW'(0)) begin
        errors++;
        $display("FAIL wr_busy: wr_en=%b wdata=%h bsel=%b grant=%0d want 1 a5a5 01 0", m_wr_en, m_wdata, m_bytesel, grant);
      end
      @(negedge clk);
    end
    wait_compl("wr", t);
    @(negedge clk);
    checks++; if (m_wr_en !== 1'b0 || m_bytesel !== 2'b00 || p_compl !== 2'b01) begin errors++;
      $display("FAIL wr_after: wr_en=%b bsel=%b p_compl=%b want 0 00 01", m_wr_en, m_bytesel, p_compl); end
    clr_req(0);
    @(negedge clk);
  endtask

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int s, t;
    apply_reset();
    ctrl_rand = 1'b1;
    set_req(0, 32'h100, 16'h1111, 1'b0, 2'b11);
    set_req(1, 32'h200, 16'h2222, 1'b0, 2'b11);
    t = -1;
    for (int a = 0; a < 4; a++) begin
      wait_start("prio", s);
      checks++; if (grant !== PW'(0) || m_addr !== 32'h100) begin errors++;
        $display("FAIL prio_grant%0d: grant=%0d addr=%h want 0 00000100", a, grant, m_addr); end
      if (a > 0) begin
        checks++; if (s - t != 3) begin errors++; $display("FAIL prio_gap%0d: %0d want 3", a, s - t); end
      end
      wait_compl("prio", t);
      @(negedge clk);
    end
  endtask
`else
  task automatic test_fairness();
    int s, t, last, e;
    apply_reset();
    ctrl_rand = 1'b1;
    set_req(0, 32'h100, 16'h1111, 1'b0, 2'b11);
    set_req(1, 32'h200, 16'h2222, 1'b0, 2'b11);
    last = NP - 1;
    t = -1;
    for (int a = 0; a < 4; a++) begin
      e = (last + 1) % NP;
      wait_start("fair", s);
      checks++; if (grant !== PW'(e) || m_addr !== 32'(32'h100 * (e + 1))) begin errors++;
        $display("FAIL fair_grant%0d: grant=%0d addr=%h want %0d", a, grant, m_addr, e); end
      if (a > 0) begin
        checks++; if (s - t != 2) begin errors++; $display("FAIL fair_gap%0d: %0d want 2", a, s - t); end
      end
      last = e;
      wait_compl("fair", t);
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_no_reissue();
    int s, t;
    apply_reset();
    ctrl_lat = 2;
    set_req(0, 32'h300, 16'h3333, 1'b0, 2'b10);
    t = -1;
    for (int a = 0; a < 3; a++) begin
      wait_start("reissue", s);
      checks++; if (grant !== PW'(0)) begin errors++; $display("FAIL reissue_grant%0d: %0d want 0", a, grant); end
      if (a > 0) begin
        checks++; if (s - t != 3) begin errors++; $display("FAIL reissue_gap%0d: %0d want 3", a, s - t); end
      end
      wait_compl("reissue", t);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_busy();
    int t;
    apply_reset();
    ctrl_lat = 30;
    set_req(1, 32'h400, 16'h4444, 1'b1, 2'b11);
    repeat (3) @(negedge clk);
    checks++; if (m_bytesel !== 2'b11) begin errors++; $display("FAIL rstbusy_busy: bsel=%b want 11", m_bytesel); end
    rst_n = 1'b0;
    clr_req(1);
    @(negedge clk);
    checks++; if (m_bytesel !== 2'b00 || m_wr_en !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 16'h0) begin errors++;
      $display("FAIL rstbusy_m: bsel=%b wr=%b addr=%h wdata=%h want 0", m_bytesel, m_wr_en, m_addr, m_wdata); end
    checks++; if (p_compl !== '0 || grant !== PW'(NP - 1)) begin errors++;
      $display("FAIL rstbusy_p: p_compl=%b grant=%0d want 0 %0d", p_compl, grant, NP - 1); end
    rst_n = 1'b1;
    @(negedge clk);
    stray_tok++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (p_compl !== '0 || m_bytesel !== 2'b00 || p_rdata !== 16'h0) begin errors++;
        $display("FAIL rstbusy_stray%0d: p_compl=%b bsel=%b rdata=%h want 0", c, p_compl, m_bytesel, p_rdata); end
    end
    ctrl_lat = 2;
    set_req(0, 32'h500, 16'h5555, 1'b0, 2'b01);
    set_req(1, 32'h600, 16'h6666, 1'b0, 2'b01);
    @(negedge clk);
    checks++; if (grant !== PW'(0) || m_addr !== 32'h500) begin errors++;
      $display("FAIL rstbusy_first: grant=%0d addr=%h want 0 00000500", grant, m_addr); end
    wait_compl("rstbusy", t);
  endtask

  task automatic test_random();
    bit            mb;
    int            mport, mlast, w;
    logic [31:0]   e_addr;
    logic [15:0]   e_wdata, e_rdata;
    logic          e_wr;
    logic [1:0]    e_bsel;
    logic [NP-1:0] e_pc, nxt;
    logic [PW-1:0] g;
    apply_reset();
    ctrl_rand = 1'b1;
    mb = 1'b0; mport = 0; mlast = NP - 1;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_wr = 1'b0; e_bsel = '0; e_pc = '0;
    for (int c = 0; c < 600; c++) begin
      // requesters: change only when idle or on their completion cycle
      for (int i = 0; i < NP; i++) begin
        if (e_pc[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i); else clr_req(i);
        end else if (p_bytesel[i*2 +: 2] == 2'b00 && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      // model step for the coming edge
      nxt = '0;
      if (mb) begin
        if (m_compl) begin
          e_rdata = m_rdata; nxt[mport] = 1'b1;
          e_bsel = 2'b00; e_wr = 1'b0; e_addr = 32'h0; mb = 1'b0;
        end
      end else begin
        w = ref_pick(p_bytesel, e_pc, mlast);
        if (w >= 0) begin
          e_addr  = p_addr[w*32 +: 32];
          e_wdata = p_wdata[w*16 +: 16];
          e_wr    = p_wr_en[w];
          e_bsel  = p_bytesel[w*2 +: 2];
          mport = w; mlast = w; mb = 1'b1;
          exp_q.push_back(PW'(w));
        end
      end
      e_pc = nxt;
      @(negedge clk);
      checks++; if (m_bytesel !== e_bsel || m_addr !== e_addr || m_wr_en !== e_wr || m_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rand_m@%0d: bsel=%b addr=%h wr=%b wd=%h want %b %h %b %h", cyc,
                 m_bytesel, m_addr, m_wr_en, m_wdata, e_bsel, e_addr, e_wr, e_wdata);
      end
      checks++; if (p_compl !== e_pc || p_rdata !== e_rdata || grant !== PW'(mlast)) begin errors++;
        $display("FAIL rand_p@%0d: compl=%b rdata=%h grant=%0d want %b %h %0d", cyc,
                 p_compl, p_rdata, grant, e_pc, e_rdata, mlast);
      end
      if (p_compl != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_sb@%0d: p_compl=%b with no access expected", cyc, p_compl);
        end else begin
          g = exp_q.pop_front();
          if (p_compl !== (NP'(1) << g)) begin errors++;
            $display("FAIL rand_sb@%0d: p_compl=%b want port %0d", cyc, p_compl, g); end
        end
      end
    end
    checks++; if (exp_q.size() > 1) begin errors++;
      $display("FAIL rand_drain: %0d accesses outstanding, want at most 1", exp_q.size()); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    p_addr = '0; p_wdata = '0; p_wr_en = '0; p_bytesel = '0;
    test_reset();
    test_single_read();
    test_write();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fairness();
`endif
    test_no_reissue();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
